// File: rtl/mem_buf_writer_pkg.sv
// rtl/mem_buf_writer_pkg.sv - shared widths, request field positions and FSM encodings for the buffer writer
package mem_buf_writer_pkg;

    localparam int AXI4S_DATA_WIDTH_DEF    = 64;
    localparam int MEM_BEAT_ADDR_WIDTH_DEF = 20;
    localparam int MEM_BUF_IDX_WIDTH_DEF   = 4;
    localparam int MEM_LENGTH_POS_DEF      = 32;
    localparam int REQ_ADDR_POS            = 0;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_REQ   = 4'd2,
        ST_DATA  = 4'd3,
        ST_DRAIN = 4'd4,
        ST_DONE  = 4'd5
    } wr_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry AXI4-Stream register slice carrying data and tlast
module axis_skid_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic                  skid_valid;

    // Upstream ready depends only on the skid register, never on m_axis_tready.
    assign s_axis_tready = !skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (m_axis_tready || !m_axis_tvalid) begin
            if (skid_valid) begin
                m_axis_tdata  <= skid_data;
                m_axis_tlast  <= skid_last;
                m_axis_tvalid <= 1'b1;
                skid_valid    <= 1'b0;
            end else begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= s_axis_tvalid;
            end
        end else if (s_axis_tvalid && !skid_valid) begin
            skid_data  <= s_axis_tdata;
            skid_last  <= s_axis_tlast;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_buf_writer.sv
// rtl/mem_buf_writer.sv - strided 2-D buffer writer: one request word per row, then that row's beats
module mem_buf_writer
    import mem_buf_writer_pkg::*;
#(
    parameter int AXI4S_DATA_WIDTH    = AXI4S_DATA_WIDTH_DEF,
    parameter int MEM_BEAT_ADDR_WIDTH = MEM_BEAT_ADDR_WIDTH_DEF,
    parameter int MEM_BUF_IDX_WIDTH   = MEM_BUF_IDX_WIDTH_DEF,
    parameter int MEM_LENGTH_POS      = MEM_LENGTH_POS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [MEM_BUF_IDX_WIDTH-1:0]   ctrl_buf_idx_in,
    input  logic [MEM_BEAT_ADDR_WIDTH-1:0] ctrl_addr_in,
    input  logic [MEM_BEAT_ADDR_WIDTH-1:0] ctrl_width_in,
    input  logic [MEM_BEAT_ADDR_WIDTH-1:0] ctrl_offset_in,
    input  logic [MEM_BEAT_ADDR_WIDTH-1:0] ctrl_count_in,
    input  logic                           ctrl_header_skip_in,
    input  logic                           ctrl_valid_in,
    output logic                           ctrl_ack_out,
    output logic                           ctrl_err_out,
    input  logic [AXI4S_DATA_WIDTH-1:0]    ctrl_rx_axis_tdata,
    input  logic                           ctrl_rx_axis_tlast,
    input  logic                           ctrl_rx_axis_tvalid,
    output logic                           ctrl_rx_axis_tready,
    output logic [AXI4S_DATA_WIDTH-1:0]    mem_tx_axis_tdata,
    output logic                           mem_tx_axis_tvalid,
    input  logic                           mem_tx_axis_tready,
    output logic [AXI4S_DATA_WIDTH-1:0]    mem_wr_axis_tdata,
    output logic                           mem_wr_axis_tlast,
    output logic                           mem_wr_axis_tvalid,
    input  logic                           mem_wr_axis_tready,
    output logic [15:0]                    rx_count_out,
    output logic [3:0]                     state_vec_out
);

    localparam logic [MEM_BEAT_ADDR_WIDTH-1:0] BEAT_ONE = {{(MEM_BEAT_ADDR_WIDTH-1){1'b0}}, 1'b1};

    wr_state_t                     state, state_n;
    logic [MEM_BUF_IDX_WIDTH-1:0]   buf_idx_r;
    logic [MEM_BEAT_ADDR_WIDTH-1:0] addr_r, width_r, offset_r, rows_left, beat_cnt;
    logic                           pad, fin, err;
    logic [15:0]                    rx_count;
    logic [3:0]                     state_vec;

    logic                           accept_cmd, set_err, set_pad, set_fin;
    logic                           start_row, row_adv, beat_inc, count_rx;
    logic                           row_last, sk_empty;
    logic [AXI4S_DATA_WIDTH-1:0]    sk_tdata;
    logic                           sk_tlast, sk_tvalid, sk_tready;
    logic [AXI4S_DATA_WIDTH-1:0]    req_word;

    always_comb begin
        req_word = '0;
        req_word[REQ_ADDR_POS +: MEM_BEAT_ADDR_WIDTH]      = addr_r;
        req_word[MEM_BEAT_ADDR_WIDTH +: MEM_BUF_IDX_WIDTH] = buf_idx_r;
        req_word[MEM_LENGTH_POS +: MEM_BEAT_ADDR_WIDTH]    = width_r;
    end

    assign mem_tx_axis_tdata  = req_word;
    assign mem_tx_axis_tvalid = (state == ST_REQ);
    assign ctrl_ack_out       = (state == ST_DONE);
    assign ctrl_err_out       = err;
    assign rx_count_out       = rx_count;
    assign state_vec_out      = state_vec;
    assign row_last           = (beat_cnt == width_r - BEAT_ONE);
    // Completion waits until every written beat has left the slice.
    assign sk_empty           = !mem_wr_axis_tvalid && sk_tready;

    always_comb begin
        state_n             = state;
        ctrl_rx_axis_tready = 1'b0;
        sk_tvalid           = 1'b0;
        sk_tdata            = '0;
        sk_tlast            = 1'b0;
        accept_cmd          = 1'b0;
        set_err             = 1'b0;
        set_pad             = 1'b0;
        set_fin             = 1'b0;
        start_row           = 1'b0;
        row_adv             = 1'b0;
        beat_inc            = 1'b0;
        count_rx            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_valid_in) begin
                    accept_cmd = 1'b1;
                    if (ctrl_count_in == '0 || ctrl_width_in == '0) state_n = ST_DONE;
                    else if (ctrl_header_skip_in)                      state_n = ST_HDR;
                    else                                               state_n = ST_REQ;
                end
            end
            ST_HDR: begin
                ctrl_rx_axis_tready = 1'b1;
                if (ctrl_rx_axis_tvalid) begin
                    if (ctrl_rx_axis_tlast) begin
                        set_err = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_tx_axis_tready) begin
                    start_row = 1'b1;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                sk_tlast = row_last;
                if (fin) begin
                    if (sk_empty) state_n = ST_DONE;
                end else if (pad) begin
                    // Early end: fill the row with zero beats so memory sees the full width.
                    sk_tvalid = 1'b1;
                    if (sk_tready) begin
                        beat_inc = 1'b1;
                        set_fin  = row_last;
                    end
                end else begin
                    ctrl_rx_axis_tready = sk_tready;
                    sk_tvalid           = ctrl_rx_axis_tvalid;
                    sk_tdata            = ctrl_rx_axis_tdata;
                    if (ctrl_rx_axis_tvalid && sk_tready) begin
                        count_rx = 1'b1;
                        beat_inc = 1'b1;
                        if (row_last) begin
                            row_adv = 1'b1;
                            if (ctrl_rx_axis_tlast) begin
                                set_fin = 1'b1;
                                set_err = (rows_left != BEAT_ONE);
                            end else if (rows_left == BEAT_ONE) begin
                                set_err = 1'b1;
                                state_n = ST_DRAIN;
                            end else begin
                                state_n = ST_REQ;
                            end
                        end else if (ctrl_rx_axis_tlast) begin
                            set_err = 1'b1;
                            set_pad = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (fin) begin
                    if (sk_empty) state_n = ST_DONE;
                end else begin
                    ctrl_rx_axis_tready = 1'b1;
                    set_fin             = ctrl_rx_axis_tvalid && ctrl_rx_axis_tlast;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            state_vec <= 4'd0;
            buf_idx_r <= '0;
            addr_r    <= '0;
            width_r   <= '0;
            offset_r  <= '0;
            rows_left <= '0;
            beat_cnt  <= '0;
            pad       <= 1'b0;
            fin       <= 1'b0;
            err       <= 1'b0;
            rx_count  <= 16'd0;
        end else begin
            state     <= state_n;
            state_vec <= state;
            if (accept_cmd) begin
                buf_idx_r <= ctrl_buf_idx_in;
                addr_r    <= ctrl_addr_in;
                width_r   <= ctrl_width_in;
                offset_r  <= ctrl_offset_in;
                rows_left <= ctrl_count_in;
                beat_cnt  <= '0;
                pad       <= 1'b0;
                fin       <= 1'b0;
                err       <= (ctrl_count_in != '0) && (ctrl_width_in == '0);
                rx_count  <= 16'd0;
            end else begin
                if (set_err) err <= 1'b1;
                if (set_pad) pad <= 1'b1;
                if (set_fin) fin <= 1'b1;
                if (start_row)     beat_cnt <= '0;
                else if (beat_inc) beat_cnt <= beat_cnt + BEAT_ONE;
                if (row_adv) begin
                    rows_left <= rows_left - BEAT_ONE;
                    addr_r    <= addr_r + offset_r;
                end
                if (count_rx) rx_count <= sat_inc16(rx_count);
            end
        end
    end

    axis_skid_buf #(
        .DATA_WIDTH(AXI4S_DATA_WIDTH)
    ) u_skid (
        .clk          (clk),
        .rst          (reset),
        .s_axis_tdata (sk_tdata),
        .s_axis_tlast (sk_tlast),
        .s_axis_tvalid(sk_tvalid),
        .s_axis_tready(sk_tready),
        .m_axis_tdata (mem_wr_axis_tdata),
        .m_axis_tlast (mem_wr_axis_tlast),
        .m_axis_tvalid(mem_wr_axis_tvalid),
        .m_axis_tready(mem_wr_axis_tready)
    );

endmodule

// File: doc/mem_buf_writer.md
Name: mem_buf_writer

Overview:
- Write-direction counterpart of the memory-buffer read path. Takes a strided 2-D write command from the controller and accepts the payload on an AXI4-Stream slave, optionally dropping a leading header beat.
- For each row it issues one write request word to the memory interface, then streams that row's beats on a separate data channel.
- Sits between the controller/accelerator output stream and the mem_if write port.

Parameters:
- AXI4S_DATA_WIDTH, 64, stream and request word width.
- MEM_BEAT_ADDR_WIDTH, 20, beat address / length / count width.
- MEM_BUF_IDX_WIDTH, 4, buffer index width.
- MEM_LENGTH_POS, 32, bit position of the length field in the request word.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- ctrl_buf_idx_in  in  MEM_BUF_IDX_WIDTH  target buffer.
- ctrl_addr_in  in  MEM_BEAT_ADDR_WIDTH  first-row beat address.
- ctrl_width_in  in  MEM_BEAT_ADDR_WIDTH  beats per row.
- ctrl_offset_in  in  MEM_BEAT_ADDR_WIDTH  address stride between rows.
- ctrl_count_in  in  MEM_BEAT_ADDR_WIDTH  number of rows.
- ctrl_header_skip_in  in  1  drop the first stream beat.
- ctrl_valid_in  in  1  command valid (level).
- ctrl_ack_out  out  1  one-cycle pulse, command complete.
- ctrl_err_out  out  1  sticky framing error; cleared by the next accepted command.
- ctrl_rx_axis_tdata/tlast/tvalid  in  AXI4S_DATA_WIDTH/1/1  payload in.
- ctrl_rx_axis_tready  out  1.
- mem_tx_axis_tdata  out  AXI4S_DATA_WIDTH  write request word.
- mem_tx_axis_tvalid  out  1.
- mem_tx_axis_tready  in  1.
- mem_wr_axis_tdata/tlast/tvalid  out  AXI4S_DATA_WIDTH/1/1  write data.
- mem_wr_axis_tready  in  1.
- rx_count_out  out  16  beats accepted in the current command.
- state_vec_out  out  4  registered FSM encoding, debug only.

Behaviour:
- Request word layout: {zeros, width, zeros, buf_idx, addr}.
  - addr at [MEM_BEAT_ADDR_WIDTH-1:0], buf_idx directly above it.
  - width at [MEM_LENGTH_POS +: MEM_BEAT_ADDR_WIDTH]; all other bits 0.
- Reset: all outputs 0, FSM in IDLE, counters 0.
- FSM states: IDLE, HDR, REQ, DATA, DRAIN, DONE.
- IDLE:
  - On ctrl_valid_in, latch all ctrl_* fields, set rx_count_out=0, clear ctrl_err_out.
  - count==0 -> DONE with no traffic.
  - width==0 -> DONE with err=1.
  - Otherwise go to HDR if header_skip, else REQ.
- HDR:
  - tready=1; one accepted beat is discarded and not counted.
  - If that beat carries tlast: err=1 -> DONE.
  - Otherwise -> REQ.
- REQ:
  - Drive tvalid=1 with the current addr. Word must be stable until tready.
  - On handshake -> DATA with beat_cnt=0.
- DATA: pass-through via the skid sub-module, so ctrl_rx tready follows mem_wr space.
  - mem_wr tlast=1 on beat_cnt==width-1.
  - On the row's last beat: rows_left-=1, addr+=offset (modulo 2^MEM_BEAT_ADDR_WIDTH, wrap allowed). Go to REQ if rows_left>0, else check input tlast.
  - Input tlast on the final beat of the final row -> DONE.
  - Input tlast earlier (early end): err=1; tready drops to 0; the rest of the current row is padded with zero beats so memory sees the full width. No further rows are requested. -> DONE after the padded row's tlast.
  - Final beat without input tlast (late end) -> DRAIN with err=1.
- DRAIN: tready=1, discard beats up to and including tlast -> DONE.
- DONE: ctrl_ack_out=1 for one cycle -> IDLE.
  - Ack occurs one cycle after the last mem_wr handshake leaves the skid buffer.
  - A new command is not accepted in the DONE cycle.
- Handshake rules:
  - No output valid drops before its handshake completes.
  - No combinational path from mem_wr_axis_tready to ctrl_rx_axis_tready; the skid buffer breaks it.
- Counters and debug:
  - rx_count_out increments on each accepted payload beat, excluding the header and drain beats; it saturates at 16'hFFFF.
  - state_vec_out is registered one cycle behind the FSM.
- ctrl_valid_in held high after ack starts a new command; the controller must drop it on ack.
- Reset asserted mid-transfer aborts immediately. Partial rows are not completed, and no ack is produced.

Decomposition:
- Shared package/header (the existing mem_params include): MEM_* widths, MEM_LENGTH_POS, request field positions, FSM encodings.
- One sub-module, axis_skid_buf: 2-entry AXI4-S register slice with data and tlast, parameterised on width. It is reusable on the read path.

Test Plan:
- addr=0x100, width=4, offset=0x40, count=3, no header, 12 beats with tlast on beat 12:
  - requests with addr 0x100/0x140/0x180, each with len=4;
  - mem tlast on beats 4/8/12;
  - one ack, err=0, rx_count=12.
- header_skip=1, width=2, count=1, 3 beats: first beat absent on mem_wr; 2 beats written; ack; rx_count=2.
- Early tlast on beat 3 of width=4, count=2: beat 4 written as zeros with tlast; only one request; ack with err=1.
- Late end, width=2, count=1, tlast on beat 5: 2 beats written; beats 3-5 drained; err=1; ack after beat 5.
- Backpressure:
  - random mem_tx/mem_wr tready at 30% duty, width=8, count=4;
  - data ordering intact; tdata and tvalid stable while stalled;
  - addr 0xFFFF0 + offset 0x20 wraps to 0x00010 (MEM_BEAT_ADDR_WIDTH=20).
- count=0 -> ack within 2 cycles, no request. Reset during DATA -> all outputs 0 next cycle, no ack.
